keypad_scan_debounce: RTL
=========================

Name: keypad_scan_debounce

Overview:
- Upstream feeder of the keypad one-hot encoder: drives the columns of a 4x4 matrix keypad, senses its rows, debounces, and presents one held 16-bit one-hot key code.
- Output `onehot` holds the last accepted key after release, so the downstream encoder sees a stable value between presses.
- Also emits a 1-cycle `key_valid` strobe and a 4-bit `key_idx` per accepted press.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 8, consecutive identical samples required to accept a press or a release; minimum 2.
- CNT_W, 16, width of the dwell counter; must satisfy 2^CNT_W > SCAN_DIV.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- row_in  in  4  keypad rows, active-low (pulled up), asynchronous to clk.
- col_out  out  4  column drive, active-low, exactly one bit low at all times.
- onehot  out  16  last accepted key; bit index = {col[1:0], row[1:0]}.
- key_idx  out  4  binary index of the last accepted key, same encoding as `onehot`.
- key_valid  out  1  1-cycle pulse when a new press is accepted.

Behaviour:
- Reset (async assert, sync release): col_out=4'b1110, onehot=16'h0000, key_idx=4'h0, key_valid=0, state=SCAN, counters=0, synchronizer flops=4'hF.
- row_in passes through a 2-flop synchronizer (rows_s). All decisions use rows_s.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. "Sample tick" = counter==SCAN_DIV-1. Rows are evaluated only on sample ticks.
- Active column index `col`: col_out = ~(4'b0001 << col).
- Row pattern classification on a sample tick:
  - "single" = exactly one bit of rows_s low.
  - "none" = 4'hF.
  - "multi" = two or more bits low.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
  - SCAN:
    - Tick with single: latch row and col into cand, db_cnt=1, go to PRESS_DB. Column is held, not advanced.
    - Tick with none or multi: col<=col+1 (wraps 3->0).
  - PRESS_DB (column frozen):
    - Tick with a single pattern equal to the latched row: db_cnt++.
    - When db_cnt reaches DEBOUNCE_SCANS: in the next cycle onehot<=1<<{col,row}, key_idx<={col,row}, key_valid=1 for exactly 1 cycle; go to HELD.
    - Any other pattern on a tick: discard cand, col<=col+1, go to SCAN. No output change.
  - HELD:
    - Tick with none: db_cnt=1, go to RELEASE_DB.
    - Any other pattern: stay. A second key in the same column is ignored; keys in other columns are not scanned.
  - RELEASE_DB:
    - Tick with none: db_cnt++. At DEBOUNCE_SCANS: col<=col+1, go to SCAN.
    - Tick with not none: go to HELD (bounce).
- onehot and key_idx change only on acceptance. They hold through release and idle.
- Re-pressing the same key produces a new key_valid pulse; onehot value is unchanged.
- Press latency: key_valid is asserted 1 cycle after the DEBOUNCE_SCANS-th matching tick.
- Minimum press to accept: DEBOUNCE_SCANS*SCAN_DIV cycles after detection, plus synchronizer delay.
- Reset mid-debounce or mid-HELD: immediately return to reset values. The key still held after reset is re-detected as a fresh press.
- db_cnt width is clog2(DEBOUNCE_SCANS+1). It saturates and never wraps.

Decomposition:
- Shared package keypad_pkg holds:
  - Localparams NUM_ROWS=4, NUM_COLS=4, KEY_W=4.
  - The state enum {SCAN, PRESS_DB, HELD, RELEASE_DB}.
  - A function row_decode(rows) returning {valid_single, row_idx[1:0]}.
- One sub-module, sync_2ff (parameterized width, reset value all-ones), for the row synchronizer.
- The FSM, dwell counter and output registers stay in this module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, keypad model pulls row r low while col_out[c]==0 and key (c,r) is pressed):
- Reset, no keys for 64 cycles -> col_out cycles 1110,1101,1011,0111 every 4 cycles; onehot=16'h0000, key_valid never high.
- Press key (col=0,row=3) steadily -> one key_valid pulse, onehot=16'h0008, key_idx=4'h3. On release, onehot stays 16'h0008 and scanning resumes.
- Press (col=3,row=1) with the row line toggling on the 2nd sample then stable -> no key_valid on the first attempt; a later accept gives onehot=16'h2000, key_idx=4'hD.
- Hold (col=2,row=0) and add (col=1,row=2) while HELD -> no second key_valid and onehot stays 16'h0100. After releasing both and pressing (1,2) alone -> onehot=16'h0040.
- Press two rows in col=1 simultaneously (rows 0 and 1) -> classified multi; no key_valid; columns keep rotating.
- Assert rst_n=0 while in PRESS_DB with key (2,3) held, release reset with key still held -> outputs reset (onehot=0), then key accepted again: onehot=16'h0800, one key_valid pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: matrix geometry, FSM states
// and the row-pattern decoder.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned KEY_W    = 4;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_e;

    // Returns {valid_single, row_idx[1:0]}; rows are active-low.
    function automatic logic [2:0] row_decode(input logic [NUM_ROWS-1:0] rows);
        logic [2:0]  res;
        int unsigned lows;
        res  = 3'b000;
        lows = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) begin
                lows++;
                res[1:0] = i[1:0];
            end
        end
        res[2] = (lows == 1);
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix lines plus the accepted-key outputs. The master side is the
// scanner; the slave side is the keypad and the downstream consumer.
interface keypad_scan_debounce_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0]          row_in;
    logic [NUM_COLS-1:0]          col_out;
    logic [NUM_ROWS*NUM_COLS-1:0] onehot;
    logic [KEY_W-1:0]             key_idx;
    logic                         key_valid;

    modport master (
        input  row_in,
        output col_out,
        output onehot,
        output key_idx,
        output key_valid
    );

    modport slave (
        output row_in,
        input  col_out,
        input  onehot,
        input  key_idx,
        input  key_valid
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so that
// idle (pulled-up) lines read as released.
module sync_2ff #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with press/release debounce; holds the last
// accepted key as a one-hot code and pulses key_valid once per accepted press.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 8,
    parameter int unsigned CNT_W          = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    keypad_scan_debounce_if.master kp
);

    localparam int unsigned NumKeys = NUM_ROWS * NUM_COLS;
    localparam int unsigned DbW     = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0]    CntLast  = CNT_W'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]      DbTarget = DbW'(DEBOUNCE_SCANS);
    localparam logic [NUM_COLS-1:0] ColOne   = 1;
    localparam logic [NumKeys-1:0]  KeyOne   = 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         col_q, col_d;
    logic [1:0]         cand_row_q, cand_row_d;
    logic [DbW-1:0]     db_q, db_d;
    logic [NumKeys-1:0] onehot_q, onehot_d;
    logic [KEY_W-1:0]   key_idx_q, key_idx_d;
    logic               key_valid_q, key_valid_d;

    logic [NUM_ROWS-1:0] rows_s;
    logic [2:0]          dec;
    logic                tick, single, none;
    logic [1:0]          row_idx;
    logic [DbW-1:0]      db_inc;

    sync_2ff #(
        .Width(NUM_ROWS)
    ) u_row_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (kp.row_in),
        .q_o  (rows_s)
    );

    assign dec     = row_decode(rows_s);
    assign single  = dec[2];
    assign row_idx = dec[1:0];
    assign none    = (rows_s == '1);
    assign tick    = (cnt_q == CntLast);
    assign db_inc  = (db_q == DbTarget) ? db_q : db_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        db_d        = db_q;
        onehot_d    = onehot_q;
        key_idx_d   = key_idx_q;
        key_valid_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single) begin
                        cand_row_d = row_idx;
                        db_d       = DbW'(1);
                        state_d    = PRESS_DB;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (single && (row_idx == cand_row_q)) begin
                        db_d = db_inc;
                        if (db_inc == DbTarget) begin
                            onehot_d    = KeyOne << {col_q, cand_row_q};
                            key_idx_d   = {col_q, cand_row_q};
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        db_d    = '0;
                        col_d   = col_q + 1'b1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (none) begin
                        db_d    = DbW'(1);
                        state_d = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (none) begin
                        db_d = db_inc;
                        if (db_inc == DbTarget) begin
                            db_d    = '0;
                            col_d   = col_q + 1'b1;
                            state_d = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= '0;
            cand_row_q  <= '0;
            db_q        <= '0;
            onehot_q    <= '0;
            key_idx_q   <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            db_q        <= db_d;
            onehot_q    <= onehot_d;
            key_idx_q   <= key_idx_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.col_out   = ~(ColOne << col_q);
    assign kp.onehot    = onehot_q;
    assign kp.key_idx   = key_idx_q;
    assign kp.key_valid = key_valid_q;

endmodule
